// File: rtl/mc_control.sv
// mc_control: multi-cycle control sequencer for the MIPS-subset datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath strobe and mux select. Halts on an all-zero
// instruction, an unsupported encoding, or a data-memory wait timeout.
module mc_control #(
    parameter int DATA_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       mem_read,
    output logic       mem_write,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        ADDR   = 4'd2,
        MEM_RD = 4'd3,
        WB_LW  = 4'd4,
        MEM_WR = 4'd5,
        EXEC_R = 4'd6,
        WB_R   = 4'd7,
        EXEC_I = 4'd8,
        WB_I   = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        HALT   = 4'd12
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       halted;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_HALT = 6'h00;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    localparam int unsigned WAIT_W =
        ($clog2(DATA_WAIT_MAX + 1) > 8) ? $clog2(DATA_WAIT_MAX + 1) : 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DATA_WAIT_MAX - 1);

    state_t            r_state;
    state_t            w_next;
    logic              w_set_illegal;
    logic [5:0]        w_fn_next;
    logic              w_branch_take;
    logic [5:0]        r_op;
    logic [5:0]        r_fn;
    logic [WAIT_W-1:0] r_wait;
    logic              r_illegal;
    ctl_t              r_out;

    // Moore output pattern for a given state; alu_op in EXEC_R follows funct.
    function automatic ctl_t f_decode(input state_t s, input logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'd1;
            end
            DECODE: c.alu_src_b = 2'd3;
            EXEC_R: begin
                c.alu_src_a = 1'b1;
                case (fn)
                    FN_SUB:  c.alu_op = 3'd1;
                    FN_AND:  c.alu_op = 3'd2;
                    FN_OR:   c.alu_op = 3'd3;
                    FN_SLT:  c.alu_op = 3'd7;
                    default: c.alu_op = 3'd0;
                endcase
            end
            WB_R: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            EXEC_I, ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'd2;
            end
            WB_I:   c.reg_write = 1'b1;
            MEM_RD: c.mem_read  = 1'b1;
            WB_LW: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            MEM_WR: c.mem_write = 1'b1;
            BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'd1;
                c.pc_src    = 2'd1;
            end
            JUMP: begin
                c.pc_src   = 2'd2;
                c.pc_write = 1'b1;
            end
            HALT:    c.halted = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection, instruction dispatch and watchdog expiry.
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_fn_next     = (r_state == DECODE) ? funct : r_fn;
        case (r_state)
            FETCH: w_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_next = EXEC_R;
                            FN_HALT: w_next = HALT;
                            default: begin
                                w_next        = HALT;
                                w_set_illegal = 1'b1;
                            end
                        endcase
                    end
                    OP_LW, OP_SW:   w_next = ADDR;
                    OP_ADDI:        w_next = EXEC_I;
                    OP_BEQ, OP_BNE: w_next = BRANCH;
                    OP_J:           w_next = JUMP;
                    default: begin
                        w_next        = HALT;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            ADDR: w_next = (r_op == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD, MEM_WR: begin
                if (mem_ready) begin
                    w_next = (r_state == MEM_RD) ? WB_LW : FETCH;
                end else if (r_wait == WAIT_LAST) begin
                    w_next        = HALT;
                    w_set_illegal = 1'b1;
                end
            end
            EXEC_R: w_next = WB_R;
            EXEC_I: w_next = WB_I;
            WB_R, WB_I, WB_LW, BRANCH, JUMP: w_next = FETCH;
            HALT:    w_next = HALT;
            default: w_next = FETCH;
        endcase
    end

    // State register, latched instruction fields, wait counter and the
    // output pattern registered one cycle ahead from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_op      <= '0;
            r_fn      <= '0;
            r_wait    <= '0;
            r_illegal <= 1'b0;
            r_out     <= f_decode(FETCH, '0);
        end else begin
            r_state <= w_next;
            if (r_state == DECODE) begin
                r_op <= opcode;
                r_fn <= funct;
            end
            if ((r_state == MEM_RD || r_state == MEM_WR) && !mem_ready) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            r_out <= f_decode(w_next, w_fn_next);
        end
    end

    assign w_branch_take = ((r_op == OP_BEQ) &&  zero) ||
                           ((r_op == OP_BNE) && !zero);

    // Drive ports; reset blanks everything combinationally so an abandoned
    // memory access drops its strobe in the reset cycle itself.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = '0;
        alu_src_a  = 1'b0;
        alu_src_b  = '0;
        alu_op     = '0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        halted     = 1'b0;
        illegal    = 1'b0;
        state      = '0;
        if (!reset) begin
            ir_write   = r_out.ir_write;
            pc_write   = (r_state == BRANCH) ? w_branch_take : r_out.pc_write;
            pc_src     = r_out.pc_src;
            alu_src_a  = r_out.alu_src_a;
            alu_src_b  = r_out.alu_src_b;
            alu_op     = r_out.alu_op;
            reg_write  = r_out.reg_write;
            reg_dst    = r_out.reg_dst;
            mem_to_reg = r_out.mem_to_reg;
            mem_read   = r_out.mem_read;
            mem_write  = r_out.mem_write;
            halted     = r_out.halted;
            illegal    = r_illegal;
            state      = r_state;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed-vector bench for the multi-cycle control sequencer.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       ir_write, pc_write, alu_src_a;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op;
    logic       reg_write, reg_dst, mem_to_reg, mem_read, mem_write;
    logic       halted, illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    mc_control #(.DATA_WAIT_MAX(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .mem_read(mem_read), .mem_write(mem_write),
        .halted(halted), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
             mem_to_reg, mem_read, mem_write, halted, illegal, state} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got state=%0d ir=%b pcw=%b b=%0d want all 0",
                     state, ir_write, pc_write, alu_src_b);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'd0 ||
            alu_src_a !== 1'b0 || alu_src_b !== 2'd1 || alu_op !== 3'd0) begin
            errors++;
            $display("FAIL fetch_after_reset got st=%0d ir=%b pcw=%b src=%0d a=%b b=%0d op=%0d want 0 1 1 0 0 1 0",
                     state, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_op);
        end
    endtask

    task automatic test_rtype_add();
        logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        opcode = 6'h00; funct = 6'h20; mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp[i]) begin
                errors++;
                $display("FAIL rtype_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            if (i == 1) begin
                checks++;
                if (alu_src_b !== 2'd3 || ir_write !== 1'b0) begin
                    errors++;
                    $display("FAIL decode_outputs got b=%0d ir=%b want 3 0", alu_src_b, ir_write);
                end
            end
            if (i == 2) begin
                checks++;
                if (alu_op !== 3'd0 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0 || reg_write !== 1'b0) begin
                    errors++;
                    $display("FAIL exec_r_add got op=%0d a=%b b=%0d rw=%b want 0 1 0 0",
                             alu_op, alu_src_a, alu_src_b, reg_write);
                end
            end
            if (i == 3) begin
                checks++;
                if (reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_r got rw=%b dst=%b m2r=%b want 1 1 0", reg_write, reg_dst, mem_to_reg);
                end
            end
            tick();
        end
    endtask

    task automatic test_alu_ops();
        logic [5:0] fn [4] = '{6'h22, 6'h24, 6'h25, 6'h2a};
        logic [2:0] op [4] = '{3'd1, 3'd2, 3'd3, 3'd7};
        for (int k = 0; k < 4; k++) begin
            opcode = 6'h00; funct = fn[k];
            do_reset();
            tick();
            tick();
            checks++;
            if (state !== 4'd6 || alu_op !== op[k]) begin
                errors++;
                $display("FAIL alu_op_funct_%0h got st=%0d op=%0d want 6 %0d", fn[k], state, alu_op, op[k]);
            end
        end
    endtask

    task automatic test_addi();
        logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd8, 4'd9, 4'd0};
        opcode = 6'h08; funct = 6'h3f;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp[i]) begin
                errors++;
                $display("FAIL addi_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            if (i == 2) begin
                checks++;
                if (alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || alu_op !== 3'd0) begin
                    errors++;
                    $display("FAIL exec_i got a=%b b=%0d op=%0d want 1 2 0", alu_src_a, alu_src_b, alu_op);
                end
            end
            if (i == 3) begin
                checks++;
                if (reg_write !== 1'b1 || reg_dst !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_i got rw=%b dst=%b want 1 0", reg_write, reg_dst);
                end
            end
            tick();
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] exp [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        opcode = 6'h23; funct = 6'h00; mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i == 6) begin
                mem_ready = 1'b1;
                #1;
            end
            checks++;
            if (state !== exp[i]) begin
                errors++;
                $display("FAIL lw_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            if (i >= 3 && i <= 6) begin
                checks++;
                if (mem_read !== 1'b1 || mem_write !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_mem_read[%0d] got rd=%b wr=%b want 1 0", i, mem_read, mem_write);
                end
            end
            if (i == 7) begin
                checks++;
                if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0 || mem_read !== 1'b0) begin
                    errors++;
                    $display("FAIL wb_lw got rw=%b m2r=%b dst=%b rd=%b want 1 1 0 0",
                             reg_write, mem_to_reg, reg_dst, mem_read);
                end
            end
            tick();
        end
    endtask

    task automatic test_sw_fast();
        logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
        opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (state !== exp[i]) begin
                errors++;
                $display("FAIL sw_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            if (i == 3) begin
                checks++;
                if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
                    errors++;
                    $display("FAIL sw_mem_write got wr=%b rd=%b want 1 0", mem_write, mem_read);
                end
            end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [4] = '{6'h04, 6'h04, 6'h05, 6'h05};
        logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       pw  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k]; funct = 6'h00; zero = zs[k];
            do_reset();
            tick();
            tick();
            checks++;
            if (state !== 4'd10 || pc_write !== pw[k] || pc_src !== 2'd1 || alu_op !== 3'd1 ||
                alu_src_a !== 1'b1 || alu_src_b !== 2'd0) begin
                errors++;
                $display("FAIL branch_%0d got st=%0d pcw=%b src=%0d op=%0d a=%b b=%0d want 10 %b 1 1 1 0",
                         k, state, pc_write, pc_src, alu_op, alu_src_a, alu_src_b, pw[k]);
            end
            zero = ~zs[k];
            #1;
            checks++;
            if (pc_write !== ~pw[k]) begin
                errors++;
                $display("FAIL branch_zero_follow_%0d got %b want %b", k, pc_write, ~pw[k]);
            end
            tick();
            checks++;
            if (state !== 4'd0) begin
                errors++;
                $display("FAIL branch_return_%0d got %0d want 0", k, state);
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jump();
        opcode = 6'h02; funct = 6'h00;
        do_reset();
        tick();
        tick();
        checks++;
        if (state !== 4'd11 || pc_src !== 2'd2 || pc_write !== 1'b1 || ir_write !== 1'b0) begin
            errors++;
            $display("FAIL jump got st=%0d src=%0d pcw=%b ir=%b want 11 2 1 0", state, pc_src, pc_write, ir_write);
        end
        tick();
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL jump_return got %0d want 0", state);
        end
    endtask

    task automatic test_halt_zero();
        opcode = 6'h00; funct = 6'h00;
        do_reset();
        tick();
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL halt_decode got %0d want 1", state);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            #1;
            checks++;
            if (state !== 4'd12 || halted !== 1'b1 || illegal !== 1'b0 ||
                {ir_write, pc_write, reg_write, mem_read, mem_write, mem_to_reg, reg_dst} !== 7'd0) begin
                errors++;
                $display("FAIL halt_hold[%0d] got st=%0d h=%b il=%b ir=%b pcw=%b rw=%b want 12 1 0 0 0 0",
                         i, state, halted, illegal, ir_write, pc_write, reg_write);
            end
            tick();
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_illegal();
        logic [5:0] ops [2] = '{6'h3f, 6'h00};
        logic [5:0] fns [2] = '{6'h00, 6'h21};
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k]; funct = fns[k];
            do_reset();
            tick();
            tick();
            checks++;
            if (state !== 4'd12 || halted !== 1'b1 || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal_%0d got st=%0d h=%b il=%b want 12 1 1", k, state, halted, illegal);
            end
        end
        opcode = 6'h08;
        do_reset();
        checks++;
        if (halted !== 1'b0 || illegal !== 1'b0 || state !== 4'd0) begin
            errors++;
            $display("FAIL illegal_cleared got h=%b il=%b st=%0d want 0 0 0", halted, illegal, state);
        end
    endtask

    task automatic test_watchdog();
        logic [3:0] exp [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd12};
        opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (state !== exp[i]) begin
                errors++;
                $display("FAIL watchdog_state[%0d] got %0d want %0d", i, state, exp[i]);
            end
            if (i >= 3 && i <= 6) begin
                checks++;
                if (mem_write !== 1'b1) begin
                    errors++;
                    $display("FAIL watchdog_mem_write[%0d] got %b want 1", i, mem_write);
                end
            end
            if (i < 7) tick();
        end
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL watchdog_halt got h=%b il=%b wr=%b want 1 1 0", halted, illegal, mem_write);
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_reset_in_mem_wr();
        opcode = 6'h2b; funct = 6'h00; mem_ready = 1'b0;
        do_reset();
        tick();
        tick();
        tick();
        checks++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rst_mw_pre got st=%0d wr=%b want 5 1", state, mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0 || reg_write !== 1'b0 || state !== 4'd0) begin
            errors++;
            $display("FAIL rst_mw_drop got wr=%b rw=%b st=%0d want 0 0 0", mem_write, reg_write, state);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || ir_write !== 1'b1 || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_mw_fetch got st=%0d ir=%b wr=%b want 0 1 0", state, ir_write, mem_write);
        end
        tick();
        checks++;
        if (state !== 4'd1 || mem_write !== 1'b0 || reg_write !== 1'b0) begin
            errors++;
            $display("FAIL rst_mw_decode got st=%0d wr=%b rw=%b want 1 0 0", state, mem_write, reg_write);
        end
        mem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rtype_add();
        test_alu_ops();
        test_addi();
        test_lw_wait();
        test_sw_fast();
        test_branch();
        test_jump();
        test_halt_zero();
        test_illegal();
        test_watchdog();
        test_reset_in_mem_wr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multi-cycle control sequencer for the MIPS-subset machine datapath. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives every datapath strobe and mux select: PC register, instruction register, register file write port, ALU and data memory request. It waits on a ready handshake from data memory and raises `halted` when the program ends, either on an all-zero instruction or on an unsupported encoding.

## Interface
- `DATA_WAIT_MAX`, default 255: watchdog cycle limit for `mem_ready`; if exceeded, the block halts with `illegal=1`.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high; forces `FETCH` on the next edge.
- `opcode` in 6: `inst[31:26]`, from the instruction register.
- `funct` in 6: `inst[5:0]`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: data memory has completed the current access; may be asserted in the same cycle as the request.
- `ir_write` out 1: load instruction register.
- `pc_write` out 1: load PC.
- `pc_src` out 2: PC source. 0 = ALU result, 1 = ALUOut, 2 = jump target.
- `alu_src_a` out 1: ALU operand A. 0 = PC, 1 = A register.
- `alu_src_b` out 2: ALU operand B. 0 = B register, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate shifted left 2.
- `alu_op` out 3: ALU operation. 0 add, 1 sub, 2 and, 3 or, 7 slt.
- `reg_write`, `reg_dst`, `mem_to_reg` out 1 each: register-file write enable, destination select (1 = rd), writeback source select (1 = memory data).
- `mem_read`, `mem_write` out 1 each: data memory request strobes.
- `halted`, `illegal` out 1 each: machine stopped; stop cause was an error.
- `state` out 4: current state, for debug.

## Operation
- States and encodings: `FETCH`=0, `DECODE`=1, `ADDR`=2, `MEM_RD`=3, `WB_LW`=4, `MEM_WR`=5, `EXEC_R`=6, `WB_R`=7, `EXEC_I`=8, `WB_I`=9, `BRANCH`=10, `JUMP`=11, `HALT`=12.
- `FETCH`:
  - Outputs: `ir_write=1`, `pc_write=1`, `pc_src=0`, `alu_src_a=0`, `alu_src_b=1`, add.
  - Always goes to `DECODE`.
- `DECODE`:
  - Outputs: `alu_src_a=0`, `alu_src_b=3`, add (computes the branch target).
  - Latches `opcode` and `funct` internally.
- Dispatch from `DECODE`:
  - opcode 0x00 with funct in {0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2a slt} → `EXEC_R`.
  - opcode 0x00 with funct 0x00 → `HALT` (end of program, `illegal=0`).
  - 0x23 lw or 0x2b sw → `ADDR`.
  - 0x08 addi → `EXEC_I`.
  - 0x04 beq or 0x05 bne → `BRANCH`.
  - 0x02 j → `JUMP`.
  - Anything else → `HALT` with `illegal=1`.
- `EXEC_R`: `alu_src_a=1`, `alu_src_b=0`. `alu_op` from latched funct: 0x20→0, 0x22→1, 0x24→2, 0x25→3, 0x2a→7. Goes to `WB_R`.
- `WB_R`: `reg_write=1`, `reg_dst=1`. Goes to `FETCH`.
- `EXEC_I`: `alu_src_a=1`, `alu_src_b=2`, add. Goes to `WB_I`.
- `WB_I`: `reg_write=1`, `reg_dst=0`. Goes to `FETCH`.
- `ADDR`: `alu_src_a=1`, `alu_src_b=2`, add. Goes to `MEM_RD` for lw, `MEM_WR` for sw.
- `MEM_RD`: `mem_read=1`; held until `mem_ready`, then goes to `WB_LW`.
- `WB_LW`: `reg_write=1`, `mem_to_reg=1`, `reg_dst=0`. Goes to `FETCH`.
- `MEM_WR`: `mem_write=1`; held until `mem_ready`, then goes to `FETCH`.
- `BRANCH`:
  - Outputs: `alu_src_a=1`, `alu_src_b=0`, sub, `pc_src=1`.
  - `pc_write = (beq & zero) | (bne & !zero)`; this is the only output that depends on an input.
  - Goes to `FETCH`.
- `JUMP`: `pc_src=2`, `pc_write=1`. Goes to `FETCH`.
- `HALT`:
  - All strobes 0, `halted=1`.
  - Stays in `HALT` until `reset`.
  - `illegal` holds its value.
- Memory-wait watchdog:
  - An 8-bit-minimum wait counter clears on entering `MEM_RD` or `MEM_WR`.
  - It increments each cycle without `mem_ready`.
  - When the count reaches `DATA_WAIT_MAX` the block goes to `HALT` with `illegal=1`.
- Unspecified outputs are 0 in every state. `mem_ready` outside the memory states is ignored.

## Timing
- All outputs are decoded from the state register and latched opcode/funct. They are Moore outputs, except `pc_write` in `BRANCH`.
- Cycles per instruction with `mem_ready` held high:
  - R-type 4, addi 4.
  - lw 5, sw 4.
  - beq/bne 3, j 3.
  - Each cycle `mem_ready` is low adds one cycle to lw or sw.
- Reset:
  - While `reset=1`, all outputs are forced to 0 and `state` reads 0.
  - On the first edge after `reset` falls, `FETCH` strobes are active.
  - `halted=0` and `illegal=0` after reset.
- Reset asserted mid-instruction, including in `MEM_RD` or `MEM_WR`: the sequence is abandoned and no further `reg_write` or `mem_write` is issued. `FETCH` resumes after reset.
- `mem_ready` high in the request cycle completes the access in one cycle.

## Test plan
- Reset for 1 cycle, then an instruction with R-type add funct 0x20: states go 0,1,6,7,0. `alu_op=0` in `EXEC_R`, `reg_write=1` and `reg_dst=1` in `WB_R`.
- lw with `mem_ready` low for 3 cycles: `MEM_RD` lasts 4 cycles, `mem_read=1` throughout, `WB_LW` asserts `mem_to_reg=1`. Total 8 cycles.
- beq with `zero=1`, then beq with `zero=0`: `pc_write` is 1 then 0 in `BRANCH`, with `pc_src=1`. bne with `zero=0` gives `pc_write=1`.
- Instruction word 0x00000000: `HALT` is reached after `DECODE`, `halted=1`, `illegal=0`, all strobes 0 for 10 further cycles.
- Opcode 0x3f: `HALT` with `illegal=1`. With `DATA_WAIT_MAX=4`, sw with `mem_ready` stuck low: `HALT` with `illegal=1` after 4 wait cycles.
- Reset asserted during `MEM_WR` with `mem_ready=0`: `mem_write` drops in the reset cycle, and `FETCH` follows after reset falls.
